// File: rtl/arbiter_pkg.sv
// arbiter_pkg: shared FSM state type and default sizing for the weighted round-robin scheduler.
package arbiter_pkg;
    typedef enum logic {IDLE, GRANT} state_e;
    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_WEIGHT_W     = 4;
    localparam int DEF_STARVE_LIMIT = 64;
endpackage

// File: rtl/rotate_priority_picker.sv
// rotate_priority_picker: combinational pick of the first set request at or after ptr_i, wrapping.
module rotate_priority_picker #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        // Scan farthest-first so the closest hit to ptr_i is the last one written.
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) begin
                found_o = 1'b1;
                idx_o   = IW'((int'(ptr_i) + k) % N);
            end
        end
        onehot_o = found_o ? (N'(1) << idx_o) : '0;
    end
endmodule

// File: rtl/weighted_rr_scheduler.sv
// weighted_rr_scheduler: weighted round-robin grant with per-requester burst credit.
// Define WRR_STARVATION_MON_EN to add the starve_o port and per-requester wait counters.
module weighted_rr_scheduler
    import arbiter_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int WEIGHT_W     = DEF_WEIGHT_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                              clk_i,
    input  logic                              arst_i,
    input  logic [NUM_REQ-1:0]                req_i,
    input  logic [NUM_REQ-1:0][WEIGHT_W-1:0]  weight_i,
    input  logic                              ready_i,
    output logic [NUM_REQ-1:0]                gnt_o,
    output logic                              gnt_valid_o,
    output logic [IW-1:0]                     gnt_idx_o
`ifdef WRR_STARVATION_MON_EN
    ,
    output logic [NUM_REQ-1:0]                starve_o
`endif
);
    state_e               state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d, ptr_q, ptr_d, ptr_nxt, pick_ptr, pick_idx;
    logic [WEIGHT_W-1:0]  credit_q, credit_d, wt;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d, pick_oh;
    logic                 xfer, rel, arb, found;

    rotate_priority_picker #(.N(NUM_REQ)) u_pick (
        .req_i    (req_i),
        .ptr_i    (pick_ptr),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .found_o  (found)
    );

    always_comb begin
        xfer     = (state_q == GRANT) && ready_i && req_i[owner_q];
        rel      = (state_q == GRANT) && (!req_i[owner_q] || (xfer && credit_q == WEIGHT_W'(1)));
        ptr_nxt  = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        pick_ptr = rel ? ptr_nxt : ptr_q;
        arb      = (state_q == IDLE) || rel;
        wt       = weight_i[pick_idx];
        state_d  = arb ? (found ? GRANT : IDLE) : state_q;
        owner_d  = arb ? (found ? pick_idx : '0) : owner_q;
        gnt_d    = arb ? pick_oh : gnt_q;
        credit_d = arb ? (found ? ((wt == '0) ? WEIGHT_W'(1) : wt) : '0)
                       : (xfer ? credit_q - 1'b1 : credit_q);
        ptr_d    = rel ? ptr_nxt : ptr_q;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            credit_q <= '0;
            gnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            gnt_q    <= gnt_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = (state_q == GRANT);
    assign gnt_idx_o   = owner_q;

`ifdef WRR_STARVATION_MON_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [NUM_REQ-1:0][CW-1:0] cnt_q, cnt_d;

    // A waiter's count restarts when it drops its request or wins the next grant.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i]    = (!req_i[i] || gnt_d[i]) ? '0
                        : ((cnt_q[i] == CW'(STARVE_LIMIT)) ? cnt_q[i] : cnt_q[i] + 1'b1);
            starve_o[i] = (cnt_q[i] == CW'(STARVE_LIMIT));
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif
endmodule

// File: tb/tb_weighted_rr_scheduler.sv
// tb_weighted_rr_scheduler: directed scenarios plus randomized traffic against a behavioural grant model.
module tb_weighted_rr_scheduler;
    localparam int N   = 4;
    localparam int W   = 4;
    localparam int LIM = 8;

    logic                clk_i    = 1'b0;
    logic                arst_i   = 1'b0;
    logic                ready_i  = 1'b0;
    logic [N-1:0]        req_i    = '0;
    logic [N-1:0][W-1:0] weight_i = '0;
    logic [N-1:0]        gnt_o;
    logic                gnt_valid_o;
    logic [1:0]          gnt_idx_o;
`ifdef WRR_STARVATION_MON_EN
    logic [N-1:0]        starve_o;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int m_valid, m_owner, m_credit, m_ptr;
    int m_cnt[N];

    always #5 clk_i = ~clk_i;

    weighted_rr_scheduler #(.NUM_REQ(N), .WEIGHT_W(W), .STARVE_LIMIT(LIM)) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .req_i       (req_i),
        .weight_i    (weight_i),
        .ready_i     (ready_i),
        .gnt_o       (gnt_o),
        .gnt_valid_o (gnt_valid_o),
        .gnt_idx_o   (gnt_idx_o)
`ifdef WRR_STARVATION_MON_EN
        ,
        .starve_o    (starve_o)
`endif
    );

    task automatic m_reset();
        m_valid = 0; m_owner = 0; m_credit = 0; m_ptr = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic m_arb(input int p);
        m_valid = 0; m_owner = 0; m_credit = 0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (req_i[j] && m_valid == 0) begin
                m_valid  = 1;
                m_owner  = j;
                m_credit = (weight_i[j] == 0) ? 1 : int'(weight_i[j]);
            end
        end
    endtask

    task automatic m_next();
        int xfer;
        if (m_valid == 0) m_arb(m_ptr);
        else begin
            xfer = (ready_i && req_i[m_owner]) ? 1 : 0;
            if (!req_i[m_owner] || (xfer == 1 && m_credit == 1)) begin
                m_ptr = (m_owner + 1) % N;
                m_arb(m_ptr);
            end else if (xfer == 1) m_credit--;
        end
        for (int i = 0; i < N; i++)
            m_cnt[i] = (!req_i[i] || (m_valid == 1 && m_owner == i)) ? 0
                     : ((m_cnt[i] + 1 > LIM) ? LIM : m_cnt[i] + 1);
    endtask

    // Compare outputs against the model, advance the model on the current inputs, then clock once.
    task automatic step();
        logic [N-1:0] exp_g;
        logic [1:0]   exp_i;
        exp_g = (m_valid == 1) ? (N'(1) << m_owner) : '0;
        exp_i = (m_valid == 1) ? 2'(m_owner) : 2'd0;
        n_chk++;
        if (gnt_o !== exp_g) begin
            n_fail++; $display("FAIL gnt_o: got %b expected %b at %0t", gnt_o, exp_g, $time);
        end
        n_chk++;
        if (gnt_valid_o !== (m_valid == 1)) begin
            n_fail++; $display("FAIL gnt_valid_o: got %b expected %0d at %0t", gnt_valid_o, m_valid, $time);
        end
        n_chk++;
        if (gnt_idx_o !== exp_i) begin
            n_fail++; $display("FAIL gnt_idx_o: got %0d expected %0d at %0t", gnt_idx_o, exp_i, $time);
        end
        n_chk++;
        if (!$onehot0(gnt_o) || gnt_valid_o !== (|gnt_o)) begin
            n_fail++; $display("FAIL onehot: gnt_o %b valid %b at %0t", gnt_o, gnt_valid_o, $time);
        end
`ifdef WRR_STARVATION_MON_EN
        begin
            logic [N-1:0] exp_s;
            for (int i = 0; i < N; i++) exp_s[i] = (m_cnt[i] == LIM);
            n_chk++;
            if (starve_o !== exp_s) begin
                n_fail++; $display("FAIL starve_o: got %b expected %b at %0t", starve_o, exp_s, $time);
            end
        end
`endif
        m_next();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle(input string tag);
        n_chk++;
        if (gnt_o !== '0 || gnt_valid_o !== 1'b0 || gnt_idx_o !== 2'd0) begin
            n_fail++;
            $display("FAIL %s: got gnt %b valid %b idx %0d expected 0/0/0", tag, gnt_o, gnt_valid_o, gnt_idx_o);
        end
`ifdef WRR_STARVATION_MON_EN
        n_chk++;
        if (starve_o !== '0) begin
            n_fail++; $display("FAIL %s starve: got %b expected 0000", tag, starve_o);
        end
`endif
    endtask

    task automatic check_gnt(input string tag, input logic [N-1:0] exp);
        n_chk++;
        if (gnt_o !== exp) begin
            n_fail++; $display("FAIL %s: got gnt_o %b expected %b at %0t", tag, gnt_o, exp, $time);
        end
    endtask

    task automatic do_reset();
        weight_i = '0;
        arst_i = 1'b1;
        #1;
        check_idle("reset_async");
        @(posedge clk_i);
        #1;
        check_idle("reset_held");
        arst_i = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        req_i = '1; ready_i = 1'b1;
        do_reset();
        req_i = '0;
        step();
        step();
    endtask

    task automatic test_weighted_sequence();
        int seq[10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
        do_reset();
        weight_i[0] = 4'd1; weight_i[1] = 4'd2; weight_i[2] = 4'd3; weight_i[3] = 4'd4;
        req_i = 4'b1111; ready_i = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            n_chk++;
            if (gnt_idx_o !== 2'(seq[i % 10]) || gnt_valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL wrr_seq[%0d]: got idx %0d valid %b expected idx %0d valid 1", i, gnt_idx_o, gnt_valid_o, seq[i % 10]);
            end
            step();
        end
    endtask

    task automatic test_weight_zero();
        do_reset();
        weight_i[1] = 4'd0;
        req_i = 4'b0010; ready_i = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            check_gnt("weight_zero", 4'b0010);
            step();
        end
    endtask

    task automatic test_ready_hold();
        do_reset();
        weight_i[2] = 4'd3;
        req_i = 4'b0100; ready_i = 1'b0;
        step();
        req_i = 4'b0101;
        for (int i = 0; i < 10; i++) begin
            check_gnt("ready_low_hold", 4'b0100);
            step();
        end
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_gnt("ready_burst", 4'b0100);
            step();
        end
        check_gnt("after_burst", 4'b0001);
        step();
    endtask

    task automatic test_drop_req();
        do_reset();
        weight_i[0] = 4'd4;
        req_i = 4'b1001; ready_i = 1'b1;
        step();
        check_gnt("drop_first", 4'b0001);
        step();
        req_i = 4'b1000;
        check_gnt("drop_cycle", 4'b0001);
        step();
        check_gnt("drop_next", 4'b1000);
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        weight_i = {4'd4, 4'd4, 4'd4, 4'd4};
        req_i = 4'b1111; ready_i = 1'b1;
        step();
        step();
        step();
        arst_i = 1'b1;
        #1;
        check_idle("midtenure_reset");
        @(posedge clk_i);
        #1;
        arst_i = 1'b0;
        m_reset();
        req_i = 4'b1100;
        step();
        n_chk++;
        if (gnt_idx_o !== 2'd2 || gnt_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_owner: got idx %0d valid %b expected idx 2 valid 1", gnt_idx_o, gnt_valid_o);
        end
        step();
    endtask

    task automatic test_random();
        do_reset();
        weight_i = W'($urandom) * 16'h1111 ^ 16'($urandom);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) req_i = N'($urandom);
            if ($urandom_range(0, 4) == 0) weight_i = 16'($urandom);
            ready_i = ($urandom_range(0, 3) != 0);
            step();
        end
    endtask

`ifdef WRR_STARVATION_MON_EN
    task automatic test_starvation();
        do_reset();
        weight_i[0] = 4'd4;
        req_i = 4'b1001; ready_i = 1'b0;
        step();
        for (int i = 0; i < 12; i++) step();
        n_chk++;
        if (starve_o[3] !== 1'b1) begin
            n_fail++; $display("FAIL starve_set: got %b expected 1", starve_o[3]);
        end
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        n_chk++;
        if (gnt_o[3] !== 1'b1 || starve_o[3] !== 1'b0) begin
            n_fail++; $display("FAIL starve_clear: got gnt %b starve %b expected gnt[3]=1 starve[3]=0", gnt_o, starve_o);
        end
        step();
    endtask
`endif

    initial begin
        m_reset();
        test_reset();
        test_weighted_sequence();
        test_weight_zero();
        test_ready_hold();
        test_drop_req();
        test_async_reset();
`ifdef WRR_STARVATION_MON_EN
        test_starvation();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/weighted_rr_scheduler.md
WEIGHTED_RR_SCHEDULER -- requirements
Module: weighted_rr_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..32).
REQ-002 Parameter WEIGHT_W, default 4, width of each per-requester weight.
REQ-003 Parameter STARVE_LIMIT, default 64, starvation threshold in cycles.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk_i  input  1  clock, all state on rising edge.
REQ-006 arst_i  input  1  asynchronous active-high reset.
REQ-007 req_i  input  NUM_REQ  per-requester request level.
REQ-008 weight_i  input  NUM_REQ x WEIGHT_W  per-requester burst weight.
REQ-009 ready_i  input  1  downstream accepts the current grant's transfer.
REQ-010 gnt_o  output  NUM_REQ  registered one-hot grant, zero when idle.
REQ-011 gnt_valid_o  output  1  a grant is active this cycle.
REQ-012 gnt_idx_o  output  $clog2(NUM_REQ)  binary index of owner, 0 when idle.
REQ-013 starve_o  output  NUM_REQ  starvation flags; present only with the macro in REQ-031.

Function
REQ-014 FSM states: IDLE (no owner) and GRANT (owner held). Registers: state, owner, credit, rotating pointer ptr.
REQ-015 Transfer SHALL be defined as gnt_valid_o & ready_i & req_i[owner].
REQ-016 IDLE: if any req_i set, pick the first set bit at or after ptr (wrapping), load credit with weight_i[pick], and enter GRANT. gnt_o is asserted the next cycle (1-cycle latency).
REQ-017 weight_i SHALL be sampled only at grant award. Weight 0 is treated as 1. Changes during a tenure are ignored.
REQ-018 GRANT: gnt_valid_o=1 and gnt_o=onehot(owner). Each transfer decrements credit by 1.
REQ-019 Release occurs on a transfer with credit==1, or when req_i[owner]==0 (no transfer that cycle).
REQ-020 On release, ptr SHALL become (owner+1) mod NUM_REQ. The next owner is picked in the same cycle from req_i using the new ptr. Result is back-to-back grants with no bubble, or IDLE if none are pending.
REQ-021 A released owner with req still high is considered last in rotation. It is re-granted only if no other requester is pending.
REQ-022 ready_i low: owner, credit and gnt_o SHALL hold indefinitely.
REQ-023 Simultaneous release and new requests: the arbitration uses the req_i value sampled in the release cycle.
REQ-024 gnt_o SHALL be one-hot or zero in every cycle. gnt_valid_o == |gnt_o.

Reset
REQ-025 While arst_i is high, outputs SHALL clear immediately (asynchronously): gnt_o=0, gnt_valid_o=0, gnt_idx_o=0, starve_o=0.
REQ-026 Reset SHALL also set state=IDLE, ptr=0, credit=0, and all starvation counters=0.
REQ-027 Reset mid-tenure discards remaining credit. The first grant after release of reset goes to the lowest-index requester.

Configuration
REQ-028 Macro WRR_STARVATION_MON_EN.
REQ-029 With the macro defined: each requester has a saturating counter. It increments when req_i[i]=1 and i is not the owner. It clears when i becomes owner or req_i[i]=0.
REQ-030 With the macro defined: starve_o[i] sets when its counter reaches STARVE_LIMIT and clears when i is granted or drops req.
REQ-031 Without the macro: the starve_o port and its counters SHALL be absent. Arbitration behaviour is identical in both builds.

Structure
REQ-032 Shared package arbiter_pkg SHALL hold the FSM state enum (IDLE, GRANT) and default parameter constants.
REQ-033 Sub-module rotate_priority_picker: combinational first-set-at-or-after-pointer pick over NUM_REQ.
   - Outputs: one-hot result, index and found flag.
   - Used for both IDLE and release arbitration.

Verification
REQ-034 Bench SHALL cover the scenarios below plus a continuous one-hot and gnt_valid_o==|gnt_o check.
   - Weights {1,2,3,4}, all req high, ready_i=1: gnt_idx_o sequence 0,1,1,2,2,2,3,3,3,3 repeating with no idle cycle.
   - Weight_i[1]=0, req_i=0b0010, ready_i=1: exactly one transfer per tenure; owner 1 re-granted after release.
   - Owner 2 with weight 3, ready_i low for 10 cycles: gnt_o=0b0100 held and credit unchanged; then 3 transfers, then release.
   - Owner 0 with weight 4 drops req after 1 transfer while req_i[3]=1: gnt_o=0b1000 on the next cycle.
   - arst_i pulsed mid-tenure: gnt_o=0 and gnt_valid_o=0 within the same cycle; after release with req_i=0b1100, owner is 2.
   - WRR_STARVATION_MON_EN, STARVE_LIMIT=8, owner 0 held with ready_i low, req_i[3]=1: starve_o[3]=1 after 8 cycles, clears on grant.
